draw_sprite: RTL and testbench

DRAW_SPRITE -- requirements
Module: draw_sprite

---
 rtl/draw_sprite.sv | 205 ++++++++++++++++++++
 tb/tb_draw_sprite.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite.sv
// draw_sprite: streams a SPR_W x SPR_H sprite from a synchronous ROM to a
// framebuffer write port at one pixel per clock, offset by a latched (x, y)
// position and clipped to the SCREEN_W x SCREEN_H visible area.
//
// Optional feature: define DRAW_SPRITE_TRANSPARENT_EN to suppress writes of
// pixels whose colour equals TRANSP_COLOR (colour key).
//
// Handshake: start is a level sampled every rising edge; it is accepted only
// while the FSM is IDLE and ignored in every other state. writeEn qualifies
// X_out/Y_out/Color_out for exactly the cycle it is high; there is no
// back-pressure, the framebuffer must take every qualified pixel.
//
// Pipeline (T0 = accepted start cycle):
//   T1+k : rom_addr = k                       (fetch stage)
//   T2+k : rom_q valid, stage-1 tag/position  (data stage)
//   T3+k : registered X_out/Y_out/Color_out/writeEn
module draw_sprite #(
   parameter int                 SPR_W        = 128,
   parameter int                 SPR_H        = 128,
   parameter int                 COLOR_W      = 12,
   parameter int                 SCREEN_W     = 320,
   parameter int                 SCREEN_H     = 240,
   parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0,
   localparam int                ADDR_W       = $clog2(SPR_W * SPR_H)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [8:0]         x_pos,
   input  logic [7:0]         y_pos,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_q,
   output logic [8:0]         X_out,
   output logic [7:0]         Y_out,
   output logic [COLOR_W-1:0] Color_out,
   output logic               writeEn,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state_dbg
);

   localparam int          COL_W    = $clog2(SPR_W);
   localparam int          N_PIX    = SPR_W * SPR_H;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAW  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // FSM decoded controls
   logic fetch_en;
   logic accept;

   // Fetch counter, drain counter and latched position
   logic [ADDR_W-1:0] cnt_q,   cnt_d;
   logic              drain_q, drain_d;
   logic [8:0]        x0_q,    x0_d;
   logic [7:0]        y0_q,    y0_d;

   // Stage 1: valid tag and one-bit-wider screen coordinates
   logic              v1_q,    v1_d;
   logic [9:0]        xs1_q,   xs1_d;
   logic [8:0]        ys1_q,   ys1_d;

   // Stage 2: registered pixel outputs
   logic              we_q,    we_d;
   logic [8:0]        xo_q,    xo_d;
   logic [7:0]        yo_q,    yo_d;
   logic [COLOR_W-1:0] co_q,   co_d;

   logic [COL_W-1:0]         col;
   logic [ADDR_W-COL_W-1:0]  row;
   logic                     in_screen;
   logic                     key_pass;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DRAIN is two cycles long, DONE is one
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)            state_d = S_DRAW;
         S_DRAW:  if (cnt_q == LAST_IDX) state_d = S_DRAIN;
         S_DRAIN: if (drain_q)          state_d = S_DONE;
         S_DONE:                        state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // FSM outputs, all decoded from the registered state
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      fetch_en  = (state_q == S_DRAW);
      accept    = (state_q == S_IDLE) && start;
      rom_addr  = fetch_en ? cnt_q : '0;
      state_dbg = state_q;
   end

   // Fetch counter, drain counter and position latch
   always_comb begin
      cnt_d   = cnt_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      drain_d = 1'b0;
      if (accept) begin
         cnt_d = '0;
         x0_d  = x_pos;
         y0_d  = y_pos;
      end else if (fetch_en) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == S_DRAIN) begin
         drain_d = ~drain_q;
      end
   end

   // Stage 1: split the fetch index into column/row and add the origin
   always_comb begin
      col   = cnt_q[COL_W-1:0];
      row   = cnt_q[ADDR_W-1:COL_W];
      v1_d  = fetch_en;
      xs1_d = {1'b0, x0_q} + 10'(col);
      ys1_d = {1'b0, y0_q} + 9'(row);
   end

`ifdef DRAW_SPRITE_TRANSPARENT_EN
   // Colour key: the keyed colour never reaches the framebuffer
   always_comb begin
      key_pass = (rom_q != TRANSP_COLOR);
   end
`else
   logic unused_transp;
   assign unused_transp = ^TRANSP_COLOR;

   // No colour key: every unclipped pixel is written
   always_comb begin
      key_pass = 1'b1;
   end
`endif

   // Stage 2: clip, qualify and capture the pixel; hold outputs on empty slots
   always_comb begin
      in_screen = (xs1_q < 10'(SCREEN_W)) && (ys1_q < 9'(SCREEN_H));
      we_d      = v1_q && in_screen && key_pass;
      xo_d      = xo_q;
      yo_d      = yo_q;
      co_d      = co_q;
      if (v1_q) begin
         xo_d = xs1_q[8:0];
         yo_d = ys1_q[7:0];
         co_d = rom_q;
      end
   end

   // Datapath registers; reset also kills any in-flight pixel tags
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         drain_q <= 1'b0;
         x0_q    <= '0;
         y0_q    <= '0;
         v1_q    <= 1'b0;
         xs1_q   <= '0;
         ys1_q   <= '0;
         we_q    <= 1'b0;
         xo_q    <= '0;
         yo_q    <= '0;
         co_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         v1_q    <= v1_d;
         xs1_q   <= xs1_d;
         ys1_q   <= ys1_d;
         we_q    <= we_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         co_q    <= co_d;
      end
   end

   // Output drive
   always_comb begin
      writeEn   = we_q;
      X_out     = xo_q;
      Y_out     = yo_q;
      Color_out = co_q;
   end

endmodule

// File: tb/tb_draw_sprite.sv
// Testbench for draw_sprite with a 4x2 sprite (N = 8 pixels).
module tb_draw_sprite;

   localparam int          SPR_W   = 4;
   localparam int          SPR_H   = 2;
   localparam int          N       = SPR_W * SPR_H;
   localparam int          COLOR_W = 12;
   localparam int          SCR_W   = 320;
   localparam int          SCR_H   = 240;
   localparam logic [11:0] TRANSP  = 12'h000;

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  x_pos;
   logic [7:0]  y_pos;
   logic [2:0]  rom_addr;
   logic [11:0] rom_q;
   logic [8:0]  X_out;
   logic [7:0]  Y_out;
   logic [11:0] Color_out;
   logic        writeEn;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] rom_mem [N];
   logic [28:0] exp_q [$];

   typedef struct {
      logic [8:0] x;
      logic [7:0] y;
      int         exp_writes;
   } vec_t;

   vec_t vecs [6];

   draw_sprite #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .COLOR_W (COLOR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .X_out     (X_out),
      .Y_out     (Y_out),
      .Color_out (Color_out),
      .writeEn   (writeEn),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous sprite ROM
   initial rom_q = '0;
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: what a pixel slot should look like, from the sprite rules
   function automatic void model_pixel(input int x, input int y, input int k,
                                       output int ex, output int ey,
                                       output int ec, output bit ew);
      int sx, sy;
      sx = x + (k % SPR_W);
      sy = y + (k / SPR_W);
      ex = sx % 512;
      ey = sy % 256;
      ec = int'(rom_mem[k]);
      ew = (sx < SCR_W) && (sy < SCR_H);
`ifdef DRAW_SPRITE_TRANSPARENT_EN
      if (rom_mem[k] == TRANSP) ew = 1'b0;
`endif
   endfunction

   task automatic load_rom_seq();
      for (int i = 0; i < N; i++) rom_mem[i] = 12'(i + 1);
   endtask

   task automatic load_rom_rand();
      for (int i = 0; i < N; i++) rom_mem[i] = 12'($urandom_range(0, 4095));
   endtask

   // Drives one draw starting in the current cycle (offset 0) and checks
   // every cycle for len cycles. glitch pulses start while busy and in DONE.
   task automatic run_draw(input int x, input int y, input bit glitch,
                           input int len, output int writes);
      int ex, ey, ec;
      bit ew;
      logic [28:0] got;
      writes = 0;
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         model_pixel(x, y, k, ex, ey, ec, ew);
         if (ew) exp_q.push_back({9'(ex), 8'(ey), 12'(ec)});
      end
      for (int c = 0; c < len; c++) begin
         start = (c == 0) || (glitch && (c == 4 || c == N + 3));
         if (c == 0) begin
            x_pos = 9'(x);
            y_pos = 8'(y);
         end else if (start) begin
            x_pos = 9'($urandom_range(0, 511));
            y_pos = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
         check($sformatf("busy@%0d", c), int'(busy), int'(c >= 1 && c <= N + 3));
         check($sformatf("done@%0d", c), int'(done), int'(c == N + 3));
         check($sformatf("rom_addr@%0d", c), int'(rom_addr),
               (c >= 1 && c <= N) ? c - 1 : 0);
         if (c >= 3 && c <= N + 2) begin
            model_pixel(x, y, c - 3, ex, ey, ec, ew);
            check($sformatf("we@%0d", c), int'(writeEn), int'(ew));
            check($sformatf("X@%0d", c), int'(X_out), ex);
            check($sformatf("Y@%0d", c), int'(Y_out), ey);
            check($sformatf("color@%0d", c), int'(Color_out), ec);
         end else begin
            check($sformatf("we_idle@%0d", c), int'(writeEn), 0);
         end
         if (writeEn) begin
            writes++;
            got = {X_out, Y_out, Color_out};
            if (exp_q.size() == 0) begin
               check($sformatf("extra_write@%0d", c), 1, 0);
            end else begin
               check($sformatf("write_data@%0d", c), int'(got), int'(exp_q.pop_front()));
            end
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("unwritten_pixels", exp_q.size(), 0);
   endtask

   initial begin
      int w;
      int exp_w;
      vecs[0] = '{x: 9'd10,  y: 8'd20,  exp_writes: 8};
      vecs[1] = '{x: 9'd318, y: 8'd239, exp_writes: 2};
      vecs[2] = '{x: 9'd0,   y: 8'd0,   exp_writes: 8};
      vecs[3] = '{x: 9'd316, y: 8'd238, exp_writes: 8};
      vecs[4] = '{x: 9'd319, y: 8'd0,   exp_writes: 2};
      vecs[5] = '{x: 9'd511, y: 8'd255, exp_writes: 0};

      start = 1'b0;
      x_pos = '0;
      y_pos = '0;
      load_rom_seq();

      // reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_X", int'(X_out), 0);
      check("rst_Y", int'(Y_out), 0);
      check("rst_color", int'(Color_out), 0);
      check("rst_we", int'(writeEn), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rom_addr", int'(rom_addr), 0);
      @(posedge clk);
      #1;

      // table-driven vectors
      for (int i = 0; i < 6; i++) begin
         run_draw(int'(vecs[i].x), int'(vecs[i].y), 1'b0, N + 7, w);
         check($sformatf("vec%0d_writes", i), w, vecs[i].exp_writes);
      end

      // colour key: ROM word 2 is the transparent colour
      rom_mem[2] = TRANSP;
`ifdef DRAW_SPRITE_TRANSPARENT_EN
      exp_w = 7;
`else
      exp_w = 8;
`endif
      run_draw(10, 20, 1'b0, N + 7, w);
      check("transp_writes", w, exp_w);
      load_rom_seq();

      // reset in the middle of a draw (asserted in T5)
      start = 1'b1;
      x_pos = 9'd10;
      y_pos = 8'd20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < N + 7; c++) begin
         @(negedge clk);
         check($sformatf("abort_we@%0d", c), int'(writeEn), 0);
         check($sformatf("abort_done@%0d", c), int'(done), 0);
         check($sformatf("abort_busy@%0d", c), int'(busy), 0);
         check($sformatf("abort_X@%0d", c), int'(X_out), 0);
         check($sformatf("abort_Y@%0d", c), int'(Y_out), 0);
         check($sformatf("abort_color@%0d", c), int'(Color_out), 0);
         @(posedge clk);
         #1;
      end
      run_draw(10, 20, 1'b0, N + 7, w);
      check("after_abort_writes", w, 8);

      // start while busy and in DONE ignored; start right after is accepted
      run_draw(10, 20, 1'b1, N + 4, w);
      check("glitch_writes", w, 8);
      run_draw(50, 100, 1'b0, N + 7, w);
      check("chained_writes", w, 8);

      // randomized draws against the reference model
      for (int r = 0; r < 20; r++) begin
         int rx, ry;
         load_rom_rand();
         if (r % 2 == 0) begin
            rx = $urandom_range(300, 511);
            ry = $urandom_range(220, 255);
         end else begin
            rx = $urandom_range(0, 511);
            ry = $urandom_range(0, 255);
         end
         run_draw(rx, ry, 1'b0, N + 7, w);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
